// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and widths.
package mips_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned INSTR_W     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word assembler: the first byte shifted in ends up in the top byte.
module word_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               full
);

  logic [1:0]         cnt_q;
  logic [INSTR_W-1:0] word_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (shift_en) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= {word_q[INSTR_W-9:0], byte_in};
    end
  end

  assign word = word_q;
  // High on the shift that completes a word; the counter wraps back to zero on it.
  assign full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length/payload/checksum framed byte stream into instruction memory
// while holding the processor in reset.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    word_count
);

  localparam int unsigned MaxWords = 2 ** ADDR_W;

  loader_state_e state_q, state_d;

  logic [15:0]        len_q;
  logic [7:0]         csum_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W:0]    count_q;
  logic [INSTR_W-1:0] pack_word;
  logic               pack_full;

  logic        xfer;
  logic        start_ok;
  logic [15:0] len_rx;
  logic        len_ok;
  logic        last_word;

  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && (state_q inside {StIdle, StDone, StErr});
  assign len_rx    = {len_q[15:8], byte_data};
  assign len_ok    = (len_rx != 16'd0) && (32'(len_rx) <= MaxWords);
  assign last_word = (32'(count_q) + 32'd1) == 32'(len_q);

  word_packer u_word_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .shift_en ((state_q == StData) && xfer),
    .byte_in  (byte_data),
    .word     (pack_word),
    .full     (pack_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StLenHi;
      StLenHi:               if (xfer) state_d = StLenLo;
      StLenLo:               if (xfer) state_d = len_ok ? StData : StErr;
      StData:                if (xfer && pack_full) state_d = StWrite;
      StWrite:               state_d = last_word ? StCsum : StData;
      StCsum:                if (xfer) state_d = (byte_data == csum_q) ? StDone : StErr;
      default:               state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StData, StCsum: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StWrite: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
      StDone:  done = 1'b1;
      StErr:   err  = 1'b1;
      default: ;
    endcase
    // A failed load keeps the core parked so it never runs a partial image.
    cpu_hold = busy | err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else if (start_ok) begin
      csum_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      if (state_q == StLenHi && xfer) len_q[15:8] <= byte_data;
      if (state_q == StLenLo && xfer) len_q[7:0]  <= byte_data;
      if (state_q == StData && xfer)  csum_q      <= csum_q ^ byte_data;
      if (state_q == StWrite) begin
        addr_q  <= addr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W + 1)'(1);
      end
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = imem_we ? pack_word : '0;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, error paths, backpressure and mid-load reset.
module tb_imem_loader;

  localparam int unsigned AW = 8;
  typedef logic [7:0] byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_count = 0;
  int first_addr = -1;
  int last_addr = -1;
  logic [31:0] mem [256];

  // {busy, done, err, cpu_hold, byte_ready}
  logic [4:0] status;
  assign status = {busy, done, err, cpu_hold, byte_ready};

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b0 && imem_we === 1'b1) begin
      if (wr_count == 0) first_addr = int'(imem_addr);
      last_addr = int'(imem_addr);
      mem[imem_addr] = imem_wdata;
      wr_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_log;
    wr_count   = 0;
    first_addr = -1;
    last_addr  = -1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  // Called just after a negedge; returns just after the negedge following the start edge.
  task automatic do_start;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data  = 8'hEE;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL byte_timeout got=never_ready exp=ready");
  endtask

  // Gaps are skipped on bytes that follow a WRITE so byte_valid stays high across it.
  task automatic send_frame(input byte_q_t f, input bit gaps);
    int g;
    for (int i = 0; i < f.size(); i++) begin
      g = 0;
      if (gaps && !((i > 2 && (i - 2) % 4 == 0) || i == f.size() - 1))
        g = int'($urandom_range(3, 0));
      send_byte(f[i], g);
    end
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  function automatic byte_q_t build_frame(input word_q_t w);
    byte_q_t f;
    logic [7:0] cs;
    int n;
    cs = 8'h00;
    n  = w.size();
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    foreach (w[k]) begin
      for (int j = 3; j >= 0; j--) begin
        logic [7:0] b;
        b = w[k][j*8 +: 8];
        f.push_back(b);
        cs = cs ^ b;
      end
    end
    f.push_back(cs);
    return f;
  endfunction

  byte_q_t nom = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h8C, 8'h09, 8'h00, 8'h00, 8'hA8};

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (status !== 5'b00000) begin
      failures++; $display("FAIL reset_status got=%b exp=00000", status);
    end
    checks++;
    if ({imem_we, imem_addr, imem_wdata, word_count} !== '0) begin
      failures++;
      $display("FAIL reset_mem_if got=we%b a%h d%h wc%h exp=0", imem_we, imem_addr, imem_wdata,
               word_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    int t0;
    clear_log();
    do_start();
    t0 = cyc;
    checks++;
    if (status !== 5'b10011) begin
      failures++; $display("FAIL nominal_after_start got=%b exp=10011", status);
    end
    send_frame(nom, 1'b0);
    checks++;
    if (cyc - t0 !== 13) begin
      failures++; $display("FAIL nominal_cycles got=%0d exp=13", cyc - t0);
    end
    checks++;
    if (status !== 5'b01000) begin
      failures++; $display("FAIL nominal_status got=%b exp=01000", status);
    end
    checks++;
    if (word_count !== 9'd2) begin
      failures++; $display("FAIL nominal_word_count got=%0d exp=2", word_count);
    end
    checks++;
    if (mem[0] !== 32'h20080005 || mem[1] !== 32'h8C090000) begin
      failures++;
      $display("FAIL nominal_image got=%h,%h exp=20080005,8c090000", mem[0], mem[1]);
    end
    checks++;
    if (wr_count !== 2 || first_addr !== 0) begin
      failures++; $display("FAIL nominal_writes got=n%0d a%0d exp=n2 a0", wr_count, first_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (status !== 5'b01000) begin
      failures++; $display("FAIL done_sticky got=%b exp=01000", status);
    end
  endtask

  task automatic test_bad_csum;
    byte_q_t f;
    f = nom;
    f[10] = 8'h00;
    clear_log();
    do_start();
    send_frame(f, 1'b0);
    checks++;
    if (status !== 5'b00110) begin
      failures++; $display("FAIL badcsum_status got=%b exp=00110", status);
    end
    checks++;
    if (wr_count !== 2 || mem[0] !== 32'h20080005 || mem[1] !== 32'h8C090000) begin
      failures++;
      $display("FAIL badcsum_image got=n%0d %h,%h exp=n2 20080005,8c090000", wr_count, mem[0],
               mem[1]);
    end
  endtask

  task automatic test_len_zero;
    byte_q_t f;
    f = '{8'h00, 8'h00};
    clear_log();
    do_start();
    send_frame(f, 1'b0);
    checks++;
    if (status !== 5'b00110) begin
      failures++; $display("FAIL len0_status got=%b exp=00110", status);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_count !== 0 || status !== 5'b00110) begin
      failures++; $display("FAIL len0_quiet got=n%0d st%b exp=n0 st00110", wr_count, status);
    end
  endtask

  task automatic test_oversize;
    byte_q_t f;
    word_q_t w;
    f = '{8'h01, 8'h01};
    clear_log();
    do_start();
    send_frame(f, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (status !== 5'b00110 || wr_count !== 0 || word_count !== 9'd0) begin
      failures++;
      $display("FAIL len257 got=st%b n%0d wc%0d exp=st00110 n0 wc0", status, wr_count, word_count);
    end
    for (int i = 0; i < 256; i++) w.push_back({8'(i), 8'h5A, ~8'(i), 8'h3C});
    f = build_frame(w);
    clear_log();
    do_start();
    send_frame(f, 1'b0);
    checks++;
    if (status !== 5'b01000 || word_count !== 9'h100) begin
      failures++;
      $display("FAIL len256_status got=st%b wc%0d exp=st01000 wc256", status, word_count);
    end
    checks++;
    if (wr_count !== 256 || last_addr !== 255) begin
      failures++; $display("FAIL len256_writes got=n%0d last%0d exp=n256 last255", wr_count,
                           last_addr);
    end
    checks++;
    if (mem[0] !== 32'h005AFF3C || mem[255] !== 32'hFF5A003C || mem[128] !== 32'h805A7F3C) begin
      failures++;
      $display("FAIL len256_image got=%h,%h,%h exp=005aff3c,805a7f3c,ff5a003c", mem[0], mem[128],
               mem[255]);
    end
  endtask

  task automatic test_backpressure;
    clear_log();
    do_start();
    send_frame(nom, 1'b1);
    checks++;
    if (status !== 5'b01000 || word_count !== 9'd2) begin
      failures++; $display("FAIL bp_status got=st%b wc%0d exp=st01000 wc2", status, word_count);
    end
    checks++;
    if (wr_count !== 2 || mem[0] !== 32'h20080005 || mem[1] !== 32'h8C090000) begin
      failures++;
      $display("FAIL bp_image got=n%0d %h,%h exp=n2 20080005,8c090000", wr_count, mem[0], mem[1]);
    end
  endtask

  task automatic test_reset_mid;
    byte_q_t f;
    f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    clear_log();
    do_start();
    send_frame(f, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (status !== 5'b00000) begin
      failures++; $display("FAIL midreset_status got=%b exp=00000", status);
    end
    checks++;
    if ({imem_we, imem_addr, imem_wdata, word_count} !== '0) begin
      failures++;
      $display("FAIL midreset_mem_if got=we%b a%h d%h wc%h exp=0", imem_we, imem_addr,
               imem_wdata, word_count);
    end
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    do_start();
    send_frame(nom, 1'b0);
    checks++;
    if (status !== 5'b01000 || first_addr !== 0 || wr_count !== 2) begin
      failures++;
      $display("FAIL midreset_reload got=st%b a%0d n%0d exp=st01000 a0 n2", status, first_addr,
               wr_count);
    end
    checks++;
    if (mem[0] !== 32'h20080005 || mem[1] !== 32'h8C090000) begin
      failures++;
      $display("FAIL midreset_image got=%h,%h exp=20080005,8c090000", mem[0], mem[1]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_bad_csum();
    test_len_zero();
    test_oversize();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
